// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a main + skid entry on a valid/ready handshake.
// Optional stall/flush statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
    parameter int WIDTH  = 128,
    parameter int PC_LSB = 0,
    parameter int PC_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_msg,
    input  logic             flush,
    input  logic [PC_W-1:0]  flush_pc,
    output logic [1:0]       occupancy,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
);

    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_msg;
    logic [WIDTH-1:0] skid_msg;
    logic [WIDTH-1:0] bubble_msg;
    logic             acc;
    logic             dep;

    assign in_ready  = !skid_v;
    assign out_valid = main_v;
    assign out_msg   = main_msg;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    assign acc = in_valid & in_ready;
    assign dep = main_v & out_ready;

    // A flushed stage is an all-zero bubble that still carries the PC for EPC tracking.
    always_comb begin
        bubble_msg                   = '0;
        bubble_msg[PC_LSB +: PC_W]   = flush_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_msg <= '0;
            skid_msg <= '0;
        end else if (flush) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_msg <= bubble_msg;
        end else if (!main_v || dep) begin
            if (skid_v) begin
                main_msg <= skid_msg;
                main_v   <= 1'b1;
                skid_v   <= 1'b0;
            end else if (acc) begin
                main_msg <= in_msg;
                main_v   <= 1'b1;
            end else begin
                // main_msg deliberately held so the last PC stays visible in the bubble
                main_v   <= 1'b0;
            end
        end else if (acc) begin
            skid_msg <= in_msg;
            skid_v   <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 32'h0;
            flush_q <= 32'h0;
        end else begin
            if (in_valid && !in_ready && !flush)
                stall_q <= stall_q + 32'd1;
            if (flush)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'h0;
    assign flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (default 128-bit and a 64-bit/PC_LSB=32 instance).
module tb_pipe_stage_reg;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, out_ready, flush;
    logic [127:0]  in_msg;
    logic [31:0]   flush_pc;
    logic          in_ready, out_valid;
    logic [127:0]  out_msg;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cycles, flush_count;

    logic          s_in_valid, s_out_ready, s_flush;
    logic [63:0]   s_in_msg;
    logic [31:0]   s_flush_pc;
    logic          s_in_ready, s_out_valid;
    logic [63:0]   s_out_msg;
    logic [1:0]    s_occupancy;
    logic [31:0]   s_stall_cycles, s_flush_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
        .out_valid(out_valid), .out_ready(out_ready), .out_msg(out_msg),
        .flush(flush), .flush_pc(flush_pc), .occupancy(occupancy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipe_stage_reg #(.WIDTH(64), .PC_LSB(32), .PC_W(32)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_msg(s_in_msg),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_msg(s_out_msg),
        .flush(s_flush), .flush_pc(s_flush_pc), .occupancy(s_occupancy),
        .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_msg = '0; flush_pc = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0; s_in_msg = '0; s_flush_pc = '0;
        step();
        step();
        total++;
        if ({in_ready, out_valid, occupancy} !== 4'b1000)
            $display("FAIL reset_flags got rdy=%b vld=%b occ=%0d exp rdy=1 vld=0 occ=0", in_ready, out_valid, occupancy);
        else passed++;
        total++;
        if (out_msg !== 128'h0) $display("FAIL reset_msg got %h exp 0", out_msg);
        else passed++;
        total++;
        if (stall_cycles !== 32'h0 || flush_count !== 32'h0)
            $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, flush_count);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_msg   = 128'(i);
            step();
            total++;
            if (out_msg !== 128'(i) || out_valid !== 1'b1)
                $display("FAIL stream_msg%0d got %h vld=%b exp %h vld=1", i, out_msg, out_valid, 128'(i));
            else passed++;
            total++;
            if (occupancy !== 2'd1 || in_ready !== 1'b1)
                $display("FAIL stream_occ%0d got occ=%0d rdy=%b exp occ=1 rdy=1", i, occupancy, in_ready);
            else passed++;
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || out_msg !== 128'h3)
            $display("FAIL stream_drain got vld=%b msg=%h exp vld=0 msg=3", out_valid, out_msg);
        else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_msg    = 128'hA;
        step();
        in_msg    = 128'hB;
        step();
        in_valid  = 1'b0;
        total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_msg !== 128'hA)
            $display("FAIL bp_full got occ=%0d rdy=%b msg=%h exp occ=2 rdy=0 msg=a", occupancy, in_ready, out_msg);
        else passed++;
        out_ready = 1'b1;
        step();
        total++;
        if (out_msg !== 128'hB || out_valid !== 1'b1 || in_ready !== 1'b1 || occupancy !== 2'd1)
            $display("FAIL bp_drain got msg=%h vld=%b rdy=%b occ=%0d exp msg=b vld=1 rdy=1 occ=1",
                     out_msg, out_valid, in_ready, occupancy);
        else passed++;
        step();
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0)
            $display("FAIL bp_empty got occ=%0d vld=%b exp occ=0 vld=0", occupancy, out_valid);
        else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_msg    = 128'h1111;
        step();
        in_msg    = 128'h2222;
        step();
        total++;
        if (occupancy !== 2'd2) $display("FAIL flush_prefill got occ=%0d exp 2", occupancy);
        else passed++;
        flush    = 1'b1;
        flush_pc = 32'h0000_3008;
        in_msg   = {4{32'hDEAD_BEEF}};
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
            $display("FAIL flush_state got vld=%b occ=%0d rdy=%b exp vld=0 occ=0 rdy=1", out_valid, occupancy, in_ready);
        else passed++;
        total++;
        if (out_msg !== 128'h0000_3008)
            $display("FAIL flush_pc got %h exp %h", out_msg, 128'h0000_3008);
        else passed++;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || out_msg !== 128'h0000_3008)
            $display("FAIL flush_dropped got vld=%b msg=%h exp vld=0 msg=3008", out_valid, out_msg);
        else passed++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_msg    = 128'h55;
        step();
        in_msg    = 128'h66;
        step();
        in_valid  = 1'b0;
        total++;
        if (occupancy !== 2'd2) $display("FAIL arst_prefill got occ=%0d exp 2", occupancy);
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_msg !== 128'h0 || occupancy !== 2'd0)
            $display("FAIL arst_mid got vld=%b rdy=%b msg=%h occ=%0d exp vld=0 rdy=1 msg=0 occ=0",
                     out_valid, in_ready, out_msg, occupancy);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_width64();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_msg    = 64'h1234_5678_9ABC_DEF0;
        step();
        s_in_valid  = 1'b0;
        total++;
        if (s_out_msg !== 64'h1234_5678_9ABC_DEF0 || s_out_valid !== 1'b1)
            $display("FAIL w64_load got %h vld=%b exp 123456789abcdef0 vld=1", s_out_msg, s_out_valid);
        else passed++;
        s_flush    = 1'b1;
        s_flush_pc = 32'h0000_3008;
        s_in_valid = 1'b1;
        s_in_msg   = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        total++;
        if (s_out_msg !== 64'h0000_3008_0000_0000 || s_out_valid !== 1'b0 || s_occupancy !== 2'd0)
            $display("FAIL w64_flush got %h vld=%b occ=%0d exp 0000300800000000 vld=0 occ=0",
                     s_out_msg, s_out_valid, s_occupancy);
        else passed++;
    endtask

    task automatic test_stats();
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
`ifdef PIPE_STAGE_STATS_EN
        exp_stall = 32'd5;
        exp_flush = 32'd2;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_msg    = 128'h77;
        step();
        in_msg    = 128'h88;
        step();
        in_msg    = 128'h99;
        repeat (5) step();
        in_valid  = 1'b0;
        total++;
        if (occupancy !== 2'd2 || out_msg !== 128'h77)
            $display("FAIL stats_hold got occ=%0d msg=%h exp occ=2 msg=77", occupancy, out_msg);
        else passed++;
        flush = 1'b1;
        repeat (2) step();
        flush = 1'b0;
        step();
        total++;
        if (stall_cycles !== exp_stall)
            $display("FAIL stats_stall got %0d exp %0d", stall_cycles, exp_stall);
        else passed++;
        total++;
        if (flush_count !== exp_flush)
            $display("FAIL stats_flush got %0d exp %0d", flush_count, exp_flush);
        else passed++;
    endtask

    task automatic test_back_to_back_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_msg    = 128'hC1;
        step();
        in_msg    = 128'hC2;
        step();
        // Full with out_ready high: skid moves to main, the blocked C3 is not accepted yet.
        in_msg    = 128'hC3;
        out_ready = 1'b1;
        step();
        total++;
        if (out_msg !== 128'hC2 || occupancy !== 2'd1 || in_ready !== 1'b1)
            $display("FAIL b2b_shift got msg=%h occ=%0d rdy=%b exp msg=c2 occ=1 rdy=1", out_msg, occupancy, in_ready);
        else passed++;
        step();
        in_valid = 1'b0;
        total++;
        if (out_msg !== 128'hC3 || out_valid !== 1'b1)
            $display("FAIL b2b_next got msg=%h vld=%b exp msg=c3 vld=1", out_msg, out_valid);
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_back_to_back_full();
        test_async_reset();
        test_width64();
        test_stats();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-width ID/EX pipeline latch.
- Carries an arbitrary-width stage message bundle between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer (main + skid) means a downstream stall does not combinationally stall upstream.
- A flush turns the stage into a bubble that keeps a PC value for exception/EPC tracking.
- Instantiated between every pair of stages: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- WIDTH, 128, message bundle width in bits.
- PC_LSB, 0, bit index of the PC field's LSB within the bundle.
- PC_W, 32, PC field width; PC_LSB+PC_W must be <= WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents a message.
- in_ready  out  1  stage can accept a message.
- in_msg  in  WIDTH  upstream message.
- out_valid  out  1  main entry holds a valid message.
- out_ready  in  1  downstream consumes this cycle.
- out_msg  out  WIDTH  main entry message.
- flush  in  1  squash the stage contents.
- flush_pc  in  PC_W  PC written into the bubble on flush.
- occupancy  out  2  number of valid entries (0..2).
- stall_cycles  out  32  stats counter (see Optional Feature).
- flush_count  out  32  stats counter (see Optional Feature).

Behaviour:
- State: main_v, main_msg, skid_v, skid_msg. All are registers; no output is driven combinationally from in_* or out_ready.
- Async reset: main_v=0, skid_v=0, main_msg=0, skid_msg=0.
  - Reset values of outputs: in_ready=1, out_valid=0, out_msg=0, occupancy=0, counters=0.
  - Reset asserted mid-transfer discards all contents immediately.
- Output decodes:
  - in_ready = !skid_v.
  - out_valid = main_v; out_msg = main_msg.
  - occupancy = main_v + skid_v.
- Fire definitions: acc = in_valid & in_ready; dep = main_v & out_ready.
- Priority 1, flush (overrides everything):
  - main_v<=0; skid_v<=0.
  - main_msg<=0 except main_msg[PC_LSB +: PC_W]<=flush_pc.
  - Any same-cycle acc is dropped. The dep still counts as consumed downstream.
- Priority 2, main free (!main_v | dep):
  - If skid_v: main<=skid, main_v<=1, skid_v<=0. acc is impossible here because in_ready=0.
  - Else if acc: main_msg<=in_msg, main_v<=1.
  - Else: main_v<=0 and main_msg holds its last value, so the PC stays visible in the bubble.
- Priority 3, main held (main_v & !out_ready):
  - If acc: skid_msg<=in_msg, skid_v<=1.
  - main is unchanged.
- Latency and throughput:
  - Input to output is 1 cycle when the stage is empty.
  - Sustained throughput is 1 message/cycle with out_ready held high.
  - Message order is strictly FIFO (main before skid).
- Full (occupancy=2): in_ready=0. The next dep moves skid to main, and in_ready rises the following cycle.
- Simultaneous acc and dep with skid empty: main is replaced by in_msg and main_v stays 1; no bubble.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cycles increments each cycle with in_valid & !in_ready & !flush.
  - flush_count increments each cycle with flush=1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both outputs are tied to 32'h0 and no counter registers are synthesised.

Test Plan:
- Reset then stream, WIDTH=128, out_ready=1, in_msg=1,2,3 on consecutive cycles -> out_msg=1,2,3 on the following 3 cycles with out_valid=1, occupancy=1, in_ready=1 throughout.
- Backpressure: out_ready=0, send A=0xA then B=0xB -> occupancy=2, in_ready=0, out_msg=0xA. Raise out_ready -> 0xA is consumed, then out_msg=0xB. in_ready=1 one cycle after skid drains.
- Flush with keep-PC:
  - Stage full; assert flush with flush_pc=32'h0000_3008 and in_valid=1 on the same cycle.
  - Required: next cycle out_valid=0, occupancy=0.
  - Required: out_msg[PC_LSB+:32]=0x3008 and all other bits 0; the incoming message is dropped.
- Async reset mid-operation: occupancy=2, assert reset between clock edges -> out_valid=0, in_ready=1, out_msg=0 before the next edge.
- Parameter sweep: WIDTH=64, PC_LSB=32, then the flush test -> out_msg=64'h0000_3008_0000_0000.
- With PIPE_STAGE_STATS_EN: 5 stalled-input cycles plus 2 flushes -> stall_cycles=5, flush_count=2. Without the macro -> both read 0.
